// File: rtl/btn_debounce.sv
// btn_debounce: conditions a raw asynchronous push-button/switch input into a
// clean, clock-synchronous level plus single-cycle rise/fall strobes.
// Structure: SYNC_STAGES-deep synchronizer chain feeding a counter-qualified
// four-state FSM (two stable states, two qualification states).
module btn_debounce #(
    parameter int STABLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    // Counter only ever needs to reach STABLE_CYCLES-1, so this width never wraps.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    // Reject configurations that cannot debounce or cannot synchronize safely.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("btn_debounce: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;
    logic                   busy_r;
    logic                   busy_nxt_s;

    // Synchronizer chain: pure flop-to-flop shift, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Next-state, counter and output decode for the qualification FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = CNT_ZERO;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;

        case (state_r)
            STABLE_LO: begin
                if (sync_s) begin
                    state_nxt_s = CHK_HI;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end

            CHK_HI: begin
                if (!sync_s) begin
                    // Glitch: drop the partial count, no strobe.
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = CHK_HI;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end

            STABLE_HI: begin
                if (!sync_s) begin
                    state_nxt_s = CHK_LO;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end

            CHK_LO: begin
                if (sync_s) begin
                    // Glitch: drop the partial count, no strobe.
                    state_nxt_s = STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b0;
                    fall_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = CHK_LO;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                // Unreachable encoding: recover to the reset-equivalent state.
                state_nxt_s = RESET_STATE;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = RESET_LEVEL;
            end
        endcase

        // busy mirrors the registered state, so decode it from the next state.
        busy_nxt_s = (state_nxt_s == CHK_HI) || (state_nxt_s == CHK_LO);
    end

    // FSM state, qualification counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
            cnt_r   <= CNT_ZERO;
            level_r <= RESET_LEVEL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign btn_level = level_r;
    assign btn_rise  = rise_r;
    assign btn_fall  = fall_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus pushes the expected strobe
// (kind and cycle) into a queue, a negedge monitor pops and compares whenever
// the DUT raises a strobe. A second instance checks RESET_LEVEL=1 behaviour.
module tb_btn_debounce;

    localparam int SC  = 4;
    localparam int SS  = 2;
    localparam int LAT = SC + SS;   // stimulus negedge -> strobe visible

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_in = 1'b0;
    logic btn_in2 = 1'b1;

    logic btn_level, btn_rise, btn_fall, busy;
    logic btn_level2, btn_rise2, btn_fall2, busy2;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int strobes2 = 0;
    int n;

    typedef struct {
        bit is_rise;
        int at;
    } ev_t;

    ev_t exp_q[$];

    btn_debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall), .busy(busy)
    );

    btn_debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .RESET_LEVEL(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in2),
        .btn_level(btn_level2), .btn_rise(btn_rise2), .btn_fall(btn_fall2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: match each observed strobe against the head of the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
            check_int("strobe_missed_at", cyc - 1, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (btn_rise === 1'b1 || btn_fall === 1'b1) begin
            ev_t ev;
            check_bit("no_dual_strobe", btn_rise & btn_fall, 1'b0);
            check_bit("strobe_level", btn_level, btn_rise);
            if (exp_q.size() == 0) begin
                check_int("unexpected_strobe_pending", 0, 1);
            end else begin
                ev = exp_q.pop_front();
                check_bit("strobe_kind", btn_rise, ev.is_rise);
                check_int("strobe_cycle", cyc, ev.at);
            end
        end
        if (btn_rise2 === 1'b1 || btn_fall2 === 1'b1) strobes2++;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_bit("rst_level", btn_level, 1'b0);
        check_bit("rst_rise", btn_rise, 1'b0);
        check_bit("rst_fall", btn_fall, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_level_hi", btn_level2, 1'b1);
        check_bit("rst_busy_hi", busy2, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press
        n = cyc;
        btn_in = 1'b1;
        exp_q.push_back('{1'b1, n + LAT});
        repeat (2) @(negedge clk);
        check_bit("press_busy_pre", busy, 1'b0);
        @(negedge clk);
        check_bit("press_busy_qual", busy, 1'b1);
        check_bit("press_level_pre", btn_level, 1'b0);
        repeat (3) @(negedge clk);
        check_bit("press_level", btn_level, 1'b1);
        check_bit("press_busy_commit", busy, 1'b0);
        @(negedge clk);
        check_bit("press_rise_low", btn_rise, 1'b0);
        check_bit("press_level_hold", btn_level, 1'b1);

        // Async reset from STABLE_HI, mid-cycle
        @(negedge clk);
        btn_in = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_bit("areset_level", btn_level, 1'b0);
        check_bit("areset_rise", btn_rise, 1'b0);
        check_bit("areset_fall", btn_fall, 1'b0);
        check_bit("areset_busy", busy, 1'b0);
        check_bit("areset_level_hi", btn_level2, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_bit("areset_after_level", btn_level, 1'b0);

        // Press then release
        n = cyc;
        btn_in = 1'b1;
        exp_q.push_back('{1'b1, n + LAT});
        repeat (8) @(negedge clk);
        check_bit("press2_level", btn_level, 1'b1);
        n = cyc;
        btn_in = 1'b0;
        exp_q.push_back('{1'b0, n + LAT});
        repeat (LAT - 1) @(negedge clk);
        check_bit("release_level_pre", btn_level, 1'b1);
        @(negedge clk);
        check_bit("release_level", btn_level, 1'b0);
        @(negedge clk);
        check_bit("release_fall_low", btn_fall, 1'b0);
        repeat (2) @(negedge clk);

        // Glitch: 3 cycles high, then low
        n = cyc;
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("glitch_busy", busy, 1'b1);
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("glitch_busy_drop", busy, 1'b0);
        check_bit("glitch_level", btn_level, 1'b0);
        repeat (3) @(negedge clk);
        check_bit("glitch_level_after", btn_level, 1'b0);

        // Bounce: toggle every cycle for 10 cycles, then hold high
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        n = cyc;
        btn_in = 1'b1;
        exp_q.push_back('{1'b1, n + LAT});
        repeat (10) @(negedge clk);
        check_bit("bounce_level", btn_level, 1'b1);

        // Back low before the mid-qualification reset
        n = cyc;
        btn_in = 1'b0;
        exp_q.push_back('{1'b0, n + LAT});
        repeat (8) @(negedge clk);
        check_bit("low_again_level", btn_level, 1'b0);

        // Reset while in CHK_HI with cnt=2
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        check_bit("midq_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("midq_reset_busy", busy, 1'b0);
        check_bit("midq_reset_level", btn_level, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = cyc;
        exp_q.push_back('{1'b1, n + LAT});
        repeat (LAT - 1) @(negedge clk);
        check_bit("midq_level_pre", btn_level, 1'b0);
        @(negedge clk);
        check_bit("midq_level", btn_level, 1'b1);
        repeat (3) @(negedge clk);

        // Final scoreboard and RESET_LEVEL=1 instance checks
        check_int("pending_expected", exp_q.size(), 0);
        check_int("hi_strobes", strobes2, 0);
        check_bit("hi_level_final", btn_level2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions a raw, asynchronous push-button or switch input into a clean, clock-synchronous level.
- Also produces single-cycle rise and fall strobes.
- Sits directly upstream of the register and flip-flop stages, which require a glitch-free, metastability-safe `d` input.
- Structure: a synchronizer chain, followed by a counter-qualified 4-state FSM.

Parameters:
- STABLE_CYCLES, default 1000: number of consecutive synchronized samples that must differ from the current level before it flips. Must be >= 2; elaboration error otherwise.
- SYNC_STAGES, default 2: depth of the input synchronizer chain. Must be >= 2.
- RESET_LEVEL, default 0: value of the synchronizer chain and `btn_level` while in reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- btn_in  input  1  raw asynchronous button/switch input
- btn_level  output  1  debounced, registered level
- btn_rise  output  1  one-cycle strobe on a debounced 0->1 change
- btn_fall  output  1  one-cycle strobe on a debounced 1->0 change
- busy  output  1  high while a candidate transition is being qualified

Behaviour:
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`). All flops clear on `rst_n` falling, with no clock edge needed.
- Reset values:
  - All synchronizer stages = RESET_LEVEL.
  - `btn_level` = RESET_LEVEL.
  - `btn_rise` = 0, `btn_fall` = 0, `busy` = 0.
  - Counter = 0.
  - FSM = STABLE_LO if RESET_LEVEL = 0, else STABLE_HI.
- Synchronizer: a SYNC_STAGES-deep shift register on `btn_in`. Its last stage is `s`. No logic may be placed between stages.
- Counter width: clog2(STABLE_CYCLES+1). The counter never wraps and saturates by construction.
- FSM state STABLE_LO:
  - s=1 -> go to CHK_HI, cnt<=1.
  - Otherwise hold, cnt<=0.
- FSM state CHK_HI:
  - s=0 -> go to STABLE_LO, cnt<=0 (glitch rejected, no strobe).
  - s=1 and cnt==STABLE_CYCLES-1 -> go to STABLE_HI, btn_level<=1, btn_rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- FSM states STABLE_HI and CHK_LO: mirror images of the above, asserting `btn_fall` and clearing `btn_level`.
- Latency: suppose `btn_in` changes and meets setup before edge E0, then stays stable. `s` is first sampled by the FSM at edge E(SYNC_STAGES). The commit happens at edge E(SYNC_STAGES+STABLE_CYCLES-1). `btn_level` and the strobe are visible right after that edge.
- Strobes are high for exactly one cycle. `btn_rise` and `btn_fall` are never high together. A strobe always coincides with the cycle in which `btn_level` first shows its new value.
- `busy` = 1 exactly while the FSM is in CHK_HI or CHK_LO. It drops in the same cycle the level commits or the glitch is rejected.
- Any opposite-level sample during CHK_* restarts qualification from scratch. Partial counts are never retained.
- Reset mid-qualification: the count is discarded and no strobe is emitted. After reset releases, a full STABLE_CYCLES qualification is required.
- A `btn_in` level equal to `btn_level` at reset release produces no strobe.

Test Plan:
(Use STABLE_CYCLES=4 and SYNC_STAGES=2 unless noted.)
- Async reset: drive rst_n=0 mid-cycle with the design in STABLE_HI -> btn_level=0, rise=fall=busy=0 before the next clk edge. With RESET_LEVEL=1, btn_level=1 and no fall strobe after release.
- Clean press: btn_in 0->1 before E0 and held -> busy=1 after E2; btn_level=1 and btn_rise=1 after E5; btn_rise=0 and busy=0 after E6.
- Glitch reject: btn_in=1 for 3 cycles, then 0 -> busy pulses high, btn_level stays 0, btn_rise is never asserted, busy=0 once the glitch has passed through.
- Release: from btn_level=1, btn_in 1->0 held -> btn_fall high for one cycle after E5; btn_level=0; btn_rise stays 0.
- Bounce: btn_in toggles every cycle for 10 cycles, then holds 1 -> exactly one btn_rise pulse, 6 edges after the final 0->1 input change, and no btn_fall.
- Reset mid-qualify: assert rst_n=0 while in CHK_HI with cnt=2, release, hold btn_in=1 -> no strobe during or after reset; btn_rise only after a full 2+4 edges from reset release.
